clock_set_ctrl: RTL and testbench

Sequencing controller for the time-of-day counter. It generates the 1 Hz advance strobe from the system clock and runs the RUN / SET_HR / SET_MIN mode machine from two user buttons. It emits single-cycle increment strobes for hours and minutes, with press-and-hold auto-repeat, and provides mode and blink flags to the display. It sits between the synchronized button inputs and the timekeeping datapath; the datapath only consumes strobes.

---
 rtl/clock_set_ctrl.sv | 126 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Clock-setting sequencer: 1 Hz prescaler, RUN/SET_HR/SET_MIN mode machine, increment strobes with auto-repeat, blink flag.
// All outputs registered; button edges act on the sampling edge; no backpressure (strobe-only outputs).
module clock_set_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PER);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n, bcnt, bcnt_n;
  logic [RW-1:0] rcnt, rcnt_n, rtarget;
  logic          rep_act, rep_act_n, rep_first, rep_first_n;
  logic          btn_mode_q, btn_inc_q;
  logic          sec_tick_n, inc_hr_n, inc_min_n, clr_sec_n, blink_n;
  logic          mode_edge, inc_edge, stb;

  assign mode = state;

  always_comb begin
    mode_edge   = btn_mode & ~btn_mode_q;
    inc_edge    = btn_inc & ~btn_inc_q;
    state_n     = state;
    pre_n       = '0;
    sec_tick_n  = 1'b0;
    stb         = 1'b0;
    rep_act_n   = 1'b0;
    rep_first_n = 1'b0;
    rcnt_n      = '0;
    bcnt_n      = '0;
    blink_n     = 1'b0;
    rtarget     = rep_first ? R_DLY : R_PER;

    if (mode_edge) begin
      case (state)
        RUN:     state_n = SET_HR;
        SET_HR:  state_n = SET_MIN;
        default: state_n = RUN;
      endcase
    end

    if (state == RUN && state_n == RUN) begin
      if (pre == P_LAST) sec_tick_n = 1'b1;
      else               pre_n      = pre + 1'b1;
    end
    clr_sec_n = (state == SET_MIN) && (state_n == RUN);

    // A mode edge in the same sample cancels any increment or pending repeat
    if (state != RUN && !mode_edge && btn_inc) begin
      if (inc_edge) begin
        stb         = 1'b1;
        rep_act_n   = 1'b1;
        rep_first_n = 1'b1;
      end else if (rep_act) begin
        rep_act_n = 1'b1;
        if (rcnt + 1'b1 == rtarget) begin
          stb = 1'b1;
        end else begin
          rcnt_n      = rcnt + 1'b1;
          rep_first_n = rep_first;
        end
      end
    end
    inc_hr_n  = stb && (state == SET_HR);
    inc_min_n = stb && (state == SET_MIN);

    if (state_n != RUN) begin
      if (state_n == state && !stb) bcnt_n = (bcnt == P_LAST) ? '0 : bcnt + 1'b1;
      blink_n = (bcnt_n < P_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pre        <= '0;
      bcnt       <= '0;
      rcnt       <= '0;
      rep_act    <= 1'b0;
      rep_first  <= 1'b0;
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
      sec_tick   <= 1'b0;
      inc_hr     <= 1'b0;
      inc_min    <= 1'b0;
      clr_sec    <= 1'b0;
      blink      <= 1'b0;
    end else begin
      state      <= state_n;
      pre        <= pre_n;
      bcnt       <= bcnt_n;
      rcnt       <= rcnt_n;
      rep_act    <= rep_act_n;
      rep_first  <= rep_first_n;
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      sec_tick   <= sec_tick_n;
      inc_hr     <= inc_hr_n;
      inc_min    <= inc_min_n;
      clr_sec    <= clr_sec_n;
      blink      <= blink_n;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: timestamp-based reference model checked every cycle, plus literal event checks.
module tb_clock_set_ctrl;

  localparam int TD  = 8;
  localparam int DLY = 6;
  localparam int PER = 3;

  logic       clk, rst, btn_mode, btn_inc;
  logic       sec_tick, inc_hr, inc_min, clr_sec, blink;
  logic [1:0] mode;

  clock_set_ctrl #(.TICK_DIV(TD), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_tick(sec_tick), .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
    .mode(mode), .blink(blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: event times instead of counters
  typedef struct {
    int         n;
    int         mode;
    int         run_ref;
    int         press_k;
    int         blink_ref;
    bit         pm;
    bit         pi;
    logic [6:0] ev;
  } mstate_t;

  localparam mstate_t MS_RST = '{n: 0, mode: 0, run_ref: 0, press_k: -1, blink_ref: 0, pm: 1'b1, pi: 1'b1, ev: 7'd0};

  function automatic mstate_t model_step(mstate_t s, bit bm, bit bi);
    mstate_t r = s;
    bit me, ie, strobe;
    int d;
    r.n = s.n + 1;
    r.ev = '0;
    me = bm && !s.pm;
    ie = bi && !s.pi;
    strobe = 1'b0;
    if (me) begin
      r.mode = (s.mode + 1) % 3;
      r.press_k = -1;
      if (s.mode == 2) begin
        r.ev[3] = 1'b1;
        r.run_ref = r.n;
      end
      if (r.mode != 0) r.blink_ref = r.n;
    end else if (s.mode == 0) begin
      if ((r.n - r.run_ref) % TD == 0) r.ev[6] = 1'b1;
    end else begin
      if (!bi) r.press_k = -1;
      else if (ie) begin
        r.press_k = r.n;
        strobe = 1'b1;
      end else if (r.press_k >= 0) begin
        d = r.n - r.press_k;
        if (d == DLY || (d > DLY && (d - DLY) % PER == 0)) strobe = 1'b1;
      end
      if (strobe) begin
        r.blink_ref = r.n;
        if (s.mode == 1) r.ev[5] = 1'b1;
        else             r.ev[4] = 1'b1;
      end
    end
    r.ev[2:1] = 2'(r.mode);
    if (r.mode != 0 && ((r.n - r.blink_ref) % TD) < TD / 2) r.ev[0] = 1'b1;
    r.pm = bm;
    r.pi = bi;
    return r;
  endfunction

  mstate_t ms;
  int      cyc;

  always @(posedge clk) begin
    if (!rst) ms <= MS_RST;
    else      ms <= model_step(ms, btn_mode, btn_inc);
    cyc <= rst ? cyc + 1 : 0;
  end

  int         n_chk = 0;
  int         n_fail = 0;
  logic [6:0] olog [0:255];

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Every negedge: compare against the model, then log; inputs change 1 time unit later
  task automatic adv(input int k);
    logic [6:0] act, want;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      act  = {sec_tick, inc_hr, inc_min, clr_sec, mode, blink};
      want = rst ? ms.ev : 7'd0;
      chk($sformatf("cycle %0d outputs", cyc), int'(act), int'(want));
      if (cyc < 256) olog[cyc] = act;
      #1;
    end
  endtask

  function automatic int cnt(input int b, input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(olog[i][b]);
    return s;
  endfunction

  initial begin
    int v;
    int exp_min [6];
    exp_min = '{58, 64, 67, 70, 73, 76};
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    adv(2);
    rst = 1'b1;

    // Free-running seconds
    adv(40);
    for (int i = 1; i <= 5; i++) chk($sformatf("sec_tick at %0d", 8 * i), int'(olog[8 * i][6]), 1);
    chk("sec_tick count 1..40", cnt(6, 1, 40), 5);
    chk("inc strobes in RUN", cnt(5, 1, 40) + cnt(4, 1, 40), 0);

    // SET_HR, single press, blink pattern
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(2);
    btn_inc = 1'b1; adv(1); btn_inc = 1'b0; adv(10);
    chk("mode after first press", int'(olog[41][2:1]), 1);
    chk("inc_hr at 44", int'(olog[44][5]), 1);
    chk("inc_hr count", cnt(5, 41, 54), 1);
    chk("no sec_tick in SET", cnt(6, 41, 54), 0);
    v = 0;
    for (int i = 44; i <= 51; i++) v = (v << 1) | int'(olog[i][0]);
    chk("blink 44..51", v, 8'hF0);

    // SET_MIN, hold for 20 cycles
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(2);
    btn_inc = 1'b1; adv(20); btn_inc = 1'b0; adv(6);
    for (int i = 0; i < 6; i++) chk($sformatf("inc_min at %0d", exp_min[i]), int'(olog[exp_min[i]][4]), 1);
    chk("inc_min count 55..83", cnt(4, 55, 83), 6);

    // SET_MIN -> RUN
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(10);
    chk("clr_sec with mode 0", int'(olog[84][3:1]), 3'b100);
    chk("sec_tick 8 after clr", int'(olog[92][6]), 1);
    chk("no early sec_tick", cnt(6, 84, 91), 0);

    // Simultaneous mode and inc edges in SET_HR
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(2);
    btn_mode = 1'b1; btn_inc = 1'b1; adv(1);
    btn_mode = 1'b0; adv(10);
    btn_inc = 1'b0; adv(2);
    btn_inc = 1'b1; adv(1); btn_inc = 1'b0; adv(2);
    chk("mode edge wins", int'(olog[98][2:1]), 2);
    chk("no inc while held", cnt(5, 98, 110) + cnt(4, 98, 110), 0);
    chk("fresh press inc_min", int'(olog[111][4]), 1);

    // Reset mid-repeat in SET_HR with btn_inc held
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(1);
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(1);
    btn_inc = 1'b1; adv(8);
    chk("repeat inc_hr at 124", int'(olog[124][5]), 1);
    rst = 1'b0;
    #1;
    chk("outputs cleared by reset", int'({sec_tick, inc_hr, inc_min, clr_sec, mode, blink}), 0);
    adv(3);
    rst = 1'b1;
    adv(3);
    btn_mode = 1'b1; adv(1); btn_mode = 1'b0; adv(5);
    btn_inc = 1'b0; adv(1);
    btn_inc = 1'b1; adv(1); btn_inc = 1'b0; adv(3);
    chk("SET_HR after reset", int'(olog[4][2:1]), 1);
    chk("no inc_hr while held through reset", cnt(5, 1, 10), 0);
    chk("fresh press after reset", int'(olog[11][5]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
